// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N systolic PE array: clear, skewed operand feed, drain, row-by-row result handshake.
// Optional job cycle counter on CYC_CNT is built only when SA_CTRL_PERF_CNT_EN is defined.
module systolic_seq_ctrl #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int AW = (K > 1) ? $clog2(K) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ARRAY_CLR_N,
    output logic                 A_RD_EN,
    output logic                 B_RD_EN,
    output logic [AW-1:0]        A_RD_ADDR,
    output logic [AW-1:0]        B_RD_ADDR,
    input  logic [N*32-1:0]      A_RD_DATA,
    input  logic [N*32-1:0]      B_RD_DATA,
    output logic [N*32-1:0]      LEFT_OUT,
    output logic [N*32-1:0]      TOP_OUT,
    output logic                 RES_VALID,
    output logic [$clog2(N)-1:0] RES_ROW,
    input  logic                 RES_READY,
    output logic [31:0]          CYC_CNT
);
    localparam int CW = $clog2(K + N + 2);
    localparam int RW = $clog2(N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(K + N - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N + 1);
    localparam logic [CW-1:0] RD_LIMIT   = CW'(K);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_RESULT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] row, row_nxt;
    logic          rd_en, rd_en_d;
    logic [AW-1:0] rd_addr, rd_addr_d;
    logic          busy_d, done_d, clr_n_d, valid_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            row         <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ARRAY_CLR_N <= 1'b1;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            RES_VALID   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            row         <= row_nxt;
            BUSY        <= busy_d;
            DONE        <= done_d;
            ARRAY_CLR_N <= clr_n_d;
            rd_en       <= rd_en_d;
            rd_addr     <= rd_addr_d;
            RES_VALID   <= valid_d;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        case (state)
            S_IDLE: begin
                if (START) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                state_nxt = S_FEED;
                cnt_nxt   = '0;
            end
            S_FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_RESULT;
                    row_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RESULT: begin
                // RES_VALID is always high here, so READY alone completes the handshake
                if (RES_READY) begin
                    if (row == ROW_LAST) begin
                        state_nxt = S_IDLE;
                        row_nxt   = '0;
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops aligned with the state register
    always_comb begin
        busy_d    = (state_nxt != S_IDLE);
        done_d    = (state == S_RESULT) && (state_nxt == S_IDLE);
        clr_n_d   = (state_nxt != S_CLEAR);
        rd_en_d   = (state_nxt == S_FEED) && (cnt_nxt < RD_LIMIT);
        rd_addr_d = rd_en_d ? cnt_nxt[AW-1:0] : '0;
        valid_d   = (state_nxt == S_RESULT);
    end

    assign A_RD_EN   = rd_en;
    assign B_RD_EN   = rd_en;
    assign A_RD_ADDR = rd_addr;
    assign B_RD_ADDR = rd_addr;
    assign RES_ROW   = row;

    // vld_pipe[i] marks lane i's skewed operand as real; bit 0 tracks the buffer's read latency
    logic [N-1:0] vld_pipe;

    always_ff @(posedge CLK) begin
        if (RST) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[N-2:0], rd_en};
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign LEFT_OUT[31:0] = vld_pipe[0] ? A_RD_DATA[31:0] : 32'h0;
            assign TOP_OUT[31:0]  = vld_pipe[0] ? B_RD_DATA[31:0] : 32'h0;
        end else begin : g_dly
            logic [i-1:0][31:0] a_sr, b_sr;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    a_sr <= '0;
                    b_sr <= '0;
                end else begin
                    a_sr[0] <= A_RD_DATA[32*i +: 32];
                    b_sr[0] <= B_RD_DATA[32*i +: 32];
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end

            assign LEFT_OUT[32*i +: 32] = vld_pipe[i] ? a_sr[i-1] : 32'h0;
            assign TOP_OUT[32*i +: 32]  = vld_pipe[i] ? b_sr[i-1] : 32'h0;
        end
    end

`ifdef SA_CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge CLK) begin
        if (RST)                     cyc_cnt <= '0;
        else if (state_nxt == S_CLEAR) cyc_cnt <= '0;
        else if (state != S_IDLE)    cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign CYC_CNT = cyc_cnt;
`else
    assign CYC_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl (N=K=4): table of jobs checked cycle by cycle against the documented
// timing, operand skew checked through a scoreboard queue, plus reset and back-to-back sequences.
module tb_systolic_seq_ctrl;
    localparam int N      = 4;
    localparam int K      = 4;
    localparam int AW     = 2;
    localparam int RW     = 2;
    localparam int W      = N * 32;
    localparam int T_RES  = K + 2 * N + 4;
    localparam int T_DONE = K + 3 * N + 4;
`ifdef SA_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          RES_READY = 1'b1;
    logic          BUSY, DONE, ARRAY_CLR_N, A_RD_EN, B_RD_EN, RES_VALID;
    logic [AW-1:0] A_RD_ADDR, B_RD_ADDR;
    logic [W-1:0]  A_RD_DATA, B_RD_DATA, LEFT_OUT, TOP_OUT;
    logic [RW-1:0] RES_ROW;
    logic [31:0]   CYC_CNT;

    systolic_seq_ctrl #(.N(N), .K(K), .AW(AW)) u_dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .ARRAY_CLR_N(ARRAY_CLR_N), .A_RD_EN(A_RD_EN), .B_RD_EN(B_RD_EN),
        .A_RD_ADDR(A_RD_ADDR), .B_RD_ADDR(B_RD_ADDR),
        .A_RD_DATA(A_RD_DATA), .B_RD_DATA(B_RD_DATA),
        .LEFT_OUT(LEFT_OUT), .TOP_OUT(TOP_OUT),
        .RES_VALID(RES_VALID), .RES_ROW(RES_ROW), .RES_READY(RES_READY),
        .CYC_CNT(CYC_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous operand buffers; junk when not read so ungated lanes show up
    logic [W-1:0] a_mem [K];
    logic [W-1:0] b_mem [K];
    always @(posedge CLK) begin
        A_RD_DATA <= A_RD_EN ? a_mem[int'(A_RD_ADDR)] : {N{32'hDEADBEEF}};
        B_RD_DATA <= B_RD_EN ? b_mem[int'(B_RD_ADDR)] : {N{32'hBADCAFE5}};
    end

    typedef struct {
        int          seed;
        int          stall_row;
        int          stall_len;
        int          exp_done;
        logic [31:0] exp_cyc;
    } job_t;

    typedef struct {
        int          due;
        int          lane;
        logic [31:0] a;
        logic [31:0] b;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string nm, input int t, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, got, exp);
        end
    endtask

    function automatic logic [31:0] opval(input int side, input int seed, input int k, input int lane);
        return 32'(side * 32'h1000_0000 + seed * 32'h1_0000 + k * 32'h100 + lane + 1);
    endfunction

    task automatic chk_reset(input string nm, input int t);
        chk({nm, "_ctrl"}, t, W'({BUSY, DONE, ARRAY_CLR_N, A_RD_EN, B_RD_EN, RES_VALID}), W'(6'b001000));
        chk({nm, "_addr"}, t, W'({A_RD_ADDR, B_RD_ADDR}), '0);
        chk({nm, "_row"}, t, W'(RES_ROW), '0);
        chk({nm, "_cyc"}, t, W'(CYC_CNT), '0);
        chk({nm, "_left"}, t, LEFT_OUT, '0);
        chk({nm, "_top"}, t, TOP_OUT, '0);
    endtask

    // Caller sits at a negedge; START is driven in this cycle (S)
    task automatic run_job(input job_t j);
        int s, t0, te, done_at, nd, ecc;
        logic [5:0] ec;
        logic [AW-1:0] ea;
        logic [W-1:0] el, et;
        sb_t e;
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                a_mem[k][32*i +: 32] = opval(1, j.seed, k, i);
                b_mem[k][32*i +: 32] = opval(2, j.seed, k, i);
            end
        s = cyc;
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                e.due  = s + 3 + k + i;
                e.lane = i;
                e.a    = opval(1, j.seed, k, i);
                e.b    = opval(2, j.seed, k, i);
                sb.push_back(e);
            end
        t0 = T_RES + j.stall_row;
        done_at = -1;
        nd = 0;
        START = 1'b1;
        RES_READY = 1'b1;
        for (int t = 1; t <= j.exp_done + 1; t++) begin
            @(negedge CLK);
            START = 1'b0;
            if (t >= t0 + j.stall_len) te = t - j.stall_len;
            else if (t >= t0)          te = t0;
            else                       te = t;
            ec[5] = (te >= 1) && (te < T_DONE);
            ec[4] = (te == T_DONE);
            ec[3] = (te != 1);
            ec[2] = (te >= 2) && (te <= K + 1);
            ec[1] = ec[2];
            ec[0] = (te >= T_RES) && (te < T_DONE);
            chk("ctrl", t, W'({BUSY, DONE, ARRAY_CLR_N, A_RD_EN, B_RD_EN, RES_VALID}), W'(ec));
            if (ec[0]) chk("res_row", t, W'(RES_ROW), W'(te - T_RES));
            if (ec[2]) begin
                ea = AW'(te - 2);
                chk("rd_addr", t, W'({A_RD_ADDR, B_RD_ADDR}), W'({ea, ea}));
            end
            el = '0;
            et = '0;
            for (int q = sb.size() - 1; q >= 0; q--)
                if (sb[q].due == cyc) begin
                    el[32*sb[q].lane +: 32] = sb[q].a;
                    et[32*sb[q].lane +: 32] = sb[q].b;
                    sb.delete(q);
                end
            chk("left_out", t, LEFT_OUT, el);
            chk("top_out", t, TOP_OUT, et);
            ecc = PERF ? ((t < j.exp_done ? t : j.exp_done) - 1) : 0;
            chk("cyc_cnt", t, W'(CYC_CNT), W'(ecc));
            if (DONE) begin
                nd++;
                if (done_at < 0) done_at = t;
            end
            RES_READY = !((t >= t0) && (t < t0 + j.stall_len));
        end
        RES_READY = 1'b1;
        chk("done_cycle", j.seed, W'(done_at), W'(j.exp_done));
        chk("done_count", j.seed, W'(nd), W'(1));
        chk("cyc_final", j.seed, W'(CYC_CNT), W'(PERF ? j.exp_cyc : 32'd0));
        chk("sb_empty", j.seed, W'(sb.size()), '0);
        sb.delete();
    endtask

    // Start a job, assert RST in cycle S+rt, expect reset values next cycle and no DONE afterwards
    task automatic rst_seq(input string nm, input int rt);
        int bad;
        START = 1'b1;
        for (int t = 1; t <= rt; t++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        RST = 1'b1;
        @(negedge CLK);
        chk_reset(nm, rt + 1);
        RST = 1'b0;
        bad = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge CLK);
            if (DONE || BUSY) bad++;
        end
        chk({nm, "_quiet"}, rt, W'(bad), '0);
    endtask

    task automatic back_to_back();
        logic [2:0] ex;
        int nd, nc;
        nd = 0;
        nc = 0;
        START = 1'b1;
        RES_READY = 1'b1;
        for (int t = 1; t <= 2 * T_DONE; t++) begin
            @(negedge CLK);
            ex[2] = (t < T_DONE) || ((t > T_DONE) && (t < 2 * T_DONE));
            ex[1] = (t == T_DONE) || (t == 2 * T_DONE);
            ex[0] = !((t == 1) || (t == T_DONE + 1));
            chk("b2b_ctrl", t, W'({BUSY, DONE, ARRAY_CLR_N}), W'(ex));
            if (DONE) nd++;
            if (!ARRAY_CLR_N) nc++;
            if (t == 2 * T_DONE) START = 1'b0;
        end
        chk("b2b_dones", 0, W'(nd), W'(2));
        chk("b2b_clears", 0, W'(nc), W'(2));
        @(negedge CLK);
        chk("b2b_idle", 0, W'({BUSY, ARRAY_CLR_N}), W'(2'b01));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        job_t jobs[4];
        jobs[0] = '{1, 0, 0, 20, 32'd19};
        jobs[1] = '{2, 1, 5, 25, 32'd24};
        jobs[2] = '{3, 3, 2, 22, 32'd21};
        jobs[3] = '{4, 0, 1, 21, 32'd20};

        for (int k = 0; k < K; k++) begin
            a_mem[k] = '0;
            b_mem[k] = '0;
        end
        repeat (3) @(negedge CLK);
        chk_reset("reset", 0);
        RST = 1'b0;
        @(negedge CLK);

        run_job(jobs[0]);
        run_job(jobs[1]);
        rst_seq("rst_drain", K + N + 2);
        rst_seq("rst_feed", 5);
        run_job(jobs[2]);
        back_to_back();
        run_job(jobs[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
